// File: rtl/key_search_ctrl.sv
// Key-search scheduler for the RC4 datapath: walks candidate keys, runs the datapath once per
// key, and scans the decrypted message in D memory for printable plaintext (a-z or space).
`timescale 1ns/1ps
module key_search_ctrl #(
  parameter int                KEY_W     = 22,
  parameter logic [KEY_W-1:0]  KEY_START = '0,
  parameter logic [KEY_W-1:0]  KEY_END   = {KEY_W{1'b1}},
  parameter int                MSG_LEN   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             search_start,
  input  logic             search_abort,
  output logic             datapath_start,
  input  logic             datapath_done,
  output logic             datapath_done_ack,
  output logic [KEY_W-1:0] input_key,
  output logic [7:0]       chk_addr,
  input  logic [7:0]       chk_data,
  output logic             busy,
  output logic             key_found,
  output logic             key_exhausted,
  output logic [KEY_W-1:0] found_key
);

  localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, LAUNCH, WAIT_DP, CHK_ADDR, CHK_WAIT, CHK_TEST, NEXT_KEY, DRAIN, FOUND, EXHAUSTED
  } state_t;

  state_t state;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      datapath_start    <= 1'b0;
      datapath_done_ack <= 1'b0;
      input_key         <= KEY_START;
      chk_addr          <= 8'd0;
      busy              <= 1'b0;
      key_found         <= 1'b0;
      key_exhausted     <= 1'b0;
      found_key         <= '0;
    end else begin
      datapath_start    <= 1'b0;
      datapath_done_ack <= 1'b0;
      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (search_abort) begin
            state <= IDLE;
          end else if (search_start) begin
            state         <= LAUNCH;
            busy          <= 1'b1;
            key_found     <= 1'b0;
            key_exhausted <= 1'b0;
            input_key     <= KEY_START;
          end
        end
        // A done still high from an earlier run must not be mistaken for this run's completion.
        LAUNCH: begin
          if (search_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!datapath_done) begin
            datapath_start <= 1'b1;
            state          <= WAIT_DP;
          end
        end
        WAIT_DP: begin
          if (search_abort) begin
            state <= DRAIN;
          end else if (datapath_done) begin
            datapath_done_ack <= 1'b1;
            chk_addr          <= 8'd0;
            state             <= CHK_ADDR;
          end
        end
        DRAIN: begin
          if (datapath_done) begin
            datapath_done_ack <= 1'b1;
            state             <= IDLE;
            busy              <= 1'b0;
          end
        end
        CHK_ADDR: begin
          if (search_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CHK_WAIT;
          end
        end
        // Extra wait lets the registered D-memory read settle before chk_data is tested.
        CHK_WAIT: begin
          if (search_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CHK_TEST;
          end
        end
        CHK_TEST: begin
          if (search_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!is_text(chk_data)) begin
            state <= NEXT_KEY;
          end else if (chk_addr == LAST_ADDR) begin
            found_key <= input_key;
            key_found <= 1'b1;
            busy      <= 1'b0;
            state     <= FOUND;
          end else begin
            chk_addr <= chk_addr + 8'd1;
            state    <= CHK_ADDR;
          end
        end
        NEXT_KEY: begin
          if (search_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (input_key == KEY_END) begin
            key_exhausted <= 1'b1;
            busy          <= 1'b0;
            state         <= EXHAUSTED;
          end else begin
            input_key <= input_key + 1'b1;
            state     <= LAUNCH;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: behavioural datapath and registered-read D memory, vector table for
// byte acceptance, plus directed sequences for exhaustion, abort/drain, stale done and reset.
`timescale 1ns/1ps
module tb_key_search_ctrl;
  localparam int KEY_W   = 8;
  localparam int MSG_LEN = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             search_start;
  logic             search_abort;
  logic             datapath_start;
  logic             datapath_done;
  logic             datapath_done_ack;
  logic [KEY_W-1:0] input_key;
  logic [7:0]       chk_addr;
  logic [7:0]       chk_data;
  logic             busy;
  logic             key_found;
  logic             key_exhausted;
  logic [KEY_W-1:0] found_key;

  always #5 clk = ~clk;

  key_search_ctrl #(
    .KEY_W(KEY_W), .KEY_START(8'd0), .KEY_END(8'd3), .MSG_LEN(MSG_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .search_start(search_start), .search_abort(search_abort),
    .datapath_start(datapath_start), .datapath_done(datapath_done),
    .datapath_done_ack(datapath_done_ack), .input_key(input_key), .chk_addr(chk_addr),
    .chk_data(chk_data), .busy(busy), .key_found(key_found), .key_exhausted(key_exhausted),
    .found_key(found_key)
  );

  // Datapath model: done rises dp_lat cycles after start and holds until acknowledged.
  int         dp_lat = 4;
  logic       stale_done = 1'b0;
  logic       dp_run, dp_done_r;
  int         dp_cnt;
  logic [7:0] msg [4][4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_run    <= 1'b0;
      dp_done_r <= 1'b0;
      dp_cnt    <= 0;
    end else begin
      if (datapath_start) begin
        dp_run <= 1'b1;
        dp_cnt <= dp_lat;
      end else if (dp_run) begin
        if (dp_cnt <= 1) begin
          dp_run    <= 1'b0;
          dp_done_r <= 1'b1;
        end else begin
          dp_cnt <= dp_cnt - 1;
        end
      end
      if (datapath_done_ack) dp_done_r <= 1'b0;
    end
  end
  assign datapath_done = dp_done_r | stale_done;

  always @(posedge clk) chk_data <= msg[input_key[1:0]][chk_addr[1:0]];

  logic clr_cnt = 1'b0;
  int   start_cnt, ack_cnt;
  always @(posedge clk) begin
    if (clr_cnt) begin
      start_cnt <= 0;
      ack_cnt   <= 0;
    end else begin
      if (datapath_start)    start_cnt <= start_cnt + 1;
      if (datapath_done_ack) ack_cnt   <= ack_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_msg(input int k, input logic [31:0] bytes);
    for (int i = 0; i < 4; i++) msg[k][i] = bytes[8*i +: 8];
  endtask

  task automatic clear_counts();
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, busy, 0);
  endtask

  task automatic run_search(input string nm);
    clear_counts();
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    wait_idle(nm);
  endtask

  typedef struct {
    logic [7:0] val;
    int         pos;
    logic [7:0] exp_key;
    int         exp_starts;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Byte at pos of key 0's text; key 1 is always valid, so a reject lands on key 1.
    vecs[0] = '{8'h20, 0, 8'd0, 1};
    vecs[1] = '{8'h61, 3, 8'd0, 1};
    vecs[2] = '{8'h7A, 1, 8'd0, 1};
    vecs[3] = '{8'h7B, 3, 8'd1, 2};
    vecs[4] = '{8'h1F, 0, 8'd1, 2};
    vecs[5] = '{8'h60, 2, 8'd1, 2};
    vecs[6] = '{8'h41, 0, 8'd1, 2};
    vecs[7] = '{8'h21, 1, 8'd1, 2};
    vecs[8] = '{8'h00, 3, 8'd1, 2};
    vecs[9] = '{8'h6D, 2, 8'd0, 1};

    reset_n = 1'b0; search_start = 1'b0; search_abort = 1'b0;
    for (int k = 0; k < 4; k++) set_msg(k, 32'h61616161);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", datapath_start, 0);
    check("rst_ack", datapath_done_ack, 0);
    check("rst_found", key_found, 0);
    check("rst_exh", key_exhausted, 0);
    check("rst_key", input_key, 0);
    check("rst_fkey", found_key, 0);
    check("rst_addr", chk_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      set_msg(0, 32'h61616161);
      msg[0][vecs[v].pos] = vecs[v].val;
      run_search($sformatf("vec%0d", v));
      check($sformatf("vec%0d_fkey", v), found_key, vecs[v].exp_key);
      check($sformatf("vec%0d_starts", v), start_cnt, vecs[v].exp_starts);
      check($sformatf("vec%0d_found", v), key_found, 1);
    end

    // Exhaustion: no key passes; counter must stop at KEY_END.
    for (int k = 0; k < 4; k++) set_msg(k, 32'h61616100);
    set_msg(3, 32'h7B616161);
    run_search("exh");
    check("exh_flag", key_exhausted, 1);
    check("exh_found", key_found, 0);
    check("exh_starts", start_cnt, 4);
    check("exh_acks", ack_cnt, 4);
    repeat (10) @(negedge clk);
    check("exh_key_hold", input_key, 3);
    check("exh_no_more", start_cnt, 4);

    // Abort while the datapath is running: drain its done, then sit idle.
    for (int k = 0; k < 4; k++) set_msg(k, 32'h61616161);
    dp_lat = 50;
    clear_counts();
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    n = 0;
    while (start_cnt == 0 && n < 20) begin @(negedge clk); n++; end
    check("abort_launched", start_cnt, 1);
    repeat (3) @(negedge clk);
    search_abort = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_drain_busy", busy, 1);
    check("abort_drain_noack", ack_cnt, 0);
    wait_idle("abort");
    repeat (10) @(negedge clk);
    search_abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_acks", ack_cnt, 1);
    check("abort_starts", start_cnt, 1);
    check("abort_found", key_found, 0);
    check("abort_exh", key_exhausted, 0);
    check("abort_busy", busy, 0);
    dp_lat = 4;

    // Stale done on entry to LAUNCH holds off the start pulse.
    stale_done = 1'b1;
    clear_counts();
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    repeat (10) @(negedge clk);
    check("stale_nostart", start_cnt, 0);
    check("stale_busy", busy, 1);
    check("stale_noack", ack_cnt, 0);
    stale_done = 1'b0;
    wait_idle("stale");
    check("stale_starts", start_cnt, 1);
    check("stale_acks", ack_cnt, 1);
    check("stale_found", key_found, 1);
    check("stale_fkey", found_key, 0);

    // Valid text only at key 2.
    set_msg(0, 32'h61616100);
    set_msg(1, 32'h7B616161);
    set_msg(2, 32'h20617A61);
    set_msg(3, 32'h61616161);
    run_search("t1");
    check("t1_starts", start_cnt, 3);
    check("t1_acks", ack_cnt, 3);
    check("t1_fkey", found_key, 2);
    check("t1_found", key_found, 1);
    check("t1_exh", key_exhausted, 0);

    // Asynchronous reset while checking key 1's bytes.
    set_msg(0, 32'h6161611F);
    set_msg(1, 32'h61616161);
    clear_counts();
    search_start = 1'b1;
    @(negedge clk);
    search_start = 1'b0;
    n = 0;
    while (chk_addr != 8'd2 && n < 500) begin @(negedge clk); n++; end
    check("rst_mid_reach", chk_addr, 2);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_key", input_key, 0);
    check("rst_mid_addr", chk_addr, 0);
    check("rst_mid_fkey", found_key, 0);
    check("rst_mid_found", key_found, 0);
    check("rst_mid_start", datapath_start, 0);
    check("rst_mid_ack", datapath_done_ack, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_search("rst_restart");
    check("rst_restart_starts", start_cnt, 2);
    check("rst_restart_fkey", found_key, 1);
    check("rst_restart_found", key_found, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
